// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline front end: fixed instruction
// words, the fetch-stage state encoding, base opcodes used by the ID-stage
// decoder, and a saturating increment helper.
package pipe_pkg;

    // Canonical NOP (addi x0, x0, 0) used as the IF/ID bubble
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    // Halt sequence: addi x1, x0, 12 followed by jalr x0, 0(x1)
    localparam logic [31:0] HALT_INSTR0 = 32'h00c0_0093;
    localparam logic [31:0] HALT_INSTR1 = 32'h0000_8067;

    // RV32I base opcodes, shared with the ID-stage control decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Fetch-stage controller states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_fetch_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and the
// IF/ID register outputs. The master side is the fetch stage itself.
// Optional statistics counters appear when PIPE_FETCH_STATS_EN is defined.
//
// Handshake: there is no valid/ready flow control here. STALL and REDIRECT
// are level inputs sampled every rising edge; I_MEM_DI must be a
// combinational function of I_MEM_ADDR within the same cycle; VALID_IFID
// qualifies INSTR_IFID/PC_IFID and the consumer takes them whenever the
// stage is not stalled.
import pipe_pkg::*;

interface pipe_fetch_if #(
    parameter int IMEM_AW = 12
);
    logic                STALL;
    logic                REDIRECT;
    logic [31:0]         REDIRECT_PC;
    logic [31:0]         I_MEM_DI;
    logic [IMEM_AW-1:0]  I_MEM_ADDR;
    logic                I_MEM_CSN;
    logic [31:0]         INSTR_IFID;
    logic [31:0]         PC_IFID;
    logic                VALID_IFID;
    logic                HALTED;
    fetch_state_e        DBG_STATE;
`ifdef PIPE_FETCH_STATS_EN
    logic [31:0]         FETCH_CNT;
    logic [31:0]         SQUASH_CNT;
    logic [31:0]         STALL_CNT;

    modport master (
        input  STALL, REDIRECT, REDIRECT_PC, I_MEM_DI,
        output I_MEM_ADDR, I_MEM_CSN, INSTR_IFID, PC_IFID, VALID_IFID,
               HALTED, DBG_STATE, FETCH_CNT, SQUASH_CNT, STALL_CNT
    );
    modport slave (
        output STALL, REDIRECT, REDIRECT_PC, I_MEM_DI,
        input  I_MEM_ADDR, I_MEM_CSN, INSTR_IFID, PC_IFID, VALID_IFID,
               HALTED, DBG_STATE, FETCH_CNT, SQUASH_CNT, STALL_CNT
    );
`else
    modport master (
        input  STALL, REDIRECT, REDIRECT_PC, I_MEM_DI,
        output I_MEM_ADDR, I_MEM_CSN, INSTR_IFID, PC_IFID, VALID_IFID,
               HALTED, DBG_STATE
    );
    modport slave (
        output STALL, REDIRECT, REDIRECT_PC, I_MEM_DI,
        input  I_MEM_ADDR, I_MEM_CSN, INSTR_IFID, PC_IFID, VALID_IFID,
               HALTED, DBG_STATE
    );
`endif
endinterface

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register. Flush (bubble) has priority over hold (stall);
// otherwise the incoming instruction and its PC are captured as valid.
import pipe_pkg::*;

module pipe_ifid_reg (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    // Bubble on reset/flush, keep on hold, else capture the fetched word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'h0;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and feeds
// the IF/ID register. Handles stalls, EX-stage redirects and halt detection.
// Optional feature macro: PIPE_FETCH_STATS_EN (fetch/squash/stall counters).
import pipe_pkg::*;

module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic          CLK,
    input  logic          RST,
    pipe_fetch_if.master  bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         w_flush;
    logic         w_hold;
    logic         w_csn;
    logic         w_halt_match;
    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_ifid_instr;
    logic [31:0]  w_ifid_pc;
    logic         w_ifid_valid;

    // Redirect targets are word aligned; low two bits are discarded
    assign w_redirect_pc = bus.REDIRECT_PC & 32'hFFFF_FFFC;

    // The halt pair is recognised when the second word arrives behind the first
    assign w_halt_match = w_ifid_valid
                       && (w_ifid_instr == HALT_INSTR0)
                       && (bus.I_MEM_DI == HALT_INSTR1);

    // State and PC registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next-state, next-PC and IF/ID control; REDIRECT beats STALL beats fetch
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush     = 1'b0;
        w_hold      = 1'b0;
        w_csn       = 1'b1;
        case (r_state)
            BOOT: begin
                w_flush     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_csn = 1'b0;
                if (bus.REDIRECT) begin
                    w_pc_nxt = w_redirect_pc;
                    w_flush  = 1'b1;
                end else if (bus.STALL) begin
                    w_hold = 1'b1;
                end else if (w_halt_match) begin
                    // JALR is captured normally; PC stays put from here on
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            HALT: begin
                // Bubble loads on the first HALT edge and simply persists
                w_flush = 1'b1;
            end
            default: begin
                w_state_nxt = BOOT;
                w_flush     = 1'b1;
            end
        endcase
    end

    pipe_ifid_reg u_ifid (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (w_flush),
        .i_hold  (w_hold),
        .i_instr (bus.I_MEM_DI),
        .i_pc    (r_pc),
        .o_instr (w_ifid_instr),
        .o_pc    (w_ifid_pc),
        .o_valid (w_ifid_valid)
    );

    assign bus.I_MEM_ADDR = r_pc[IMEM_AW-1:0];
    assign bus.I_MEM_CSN  = w_csn;
    assign bus.INSTR_IFID = w_ifid_instr;
    assign bus.PC_IFID    = w_ifid_pc;
    assign bus.VALID_IFID = w_ifid_valid;
    assign bus.HALTED     = (r_state == HALT);
    assign bus.DBG_STATE  = r_state;

`ifdef PIPE_FETCH_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_squash_cnt;
    logic [31:0] r_stall_cnt;

    // Event counters; only RUN edges count, so they freeze in BOOT and HALT
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_cnt  <= 32'h0;
            r_squash_cnt <= 32'h0;
            r_stall_cnt  <= 32'h0;
        end else if (r_state == RUN) begin
            if (bus.REDIRECT)
                r_squash_cnt <= sat_inc(r_squash_cnt);
            else if (bus.STALL)
                r_stall_cnt  <= sat_inc(r_stall_cnt);
            else
                r_fetch_cnt  <= sat_inc(r_fetch_cnt);
        end
    end

    assign bus.FETCH_CNT  = r_fetch_cnt;
    assign bus.SQUASH_CNT = r_squash_cnt;
    assign bus.STALL_CNT  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: boot latency, stall, redirect-over-stall,
// halt sequence, PC wrap, and (with PIPE_FETCH_STATS_EN) the counters.
import pipe_pkg::*;

module tb_pipe_fetch;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [31:0] mem [0:1023];

    pipe_fetch_if #(.IMEM_AW(12)) bus ();

    pipe_fetch #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (12)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign bus.I_MEM_DI = mem[bus.I_MEM_ADDR[11:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0010_0093 + i;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.STALL       = 1'b0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 32'h0;
        load_default_mem();

        // Reset state
        do_reset();
        check_eq("rst_valid", {31'h0, bus.VALID_IFID}, 32'h0);
        check_eq("rst_instr", bus.INSTR_IFID, 32'h0000_0013);
        check_eq("rst_pc_ifid", bus.PC_IFID, 32'h0);
        check_eq("rst_halted", {31'h0, bus.HALTED}, 32'h0);
        check_eq("rst_addr", {20'h0, bus.I_MEM_ADDR}, 32'h0);
        check_eq("boot_csn", {31'h0, bus.I_MEM_CSN}, 32'h1);
        check_eq("boot_state", {30'h0, bus.DBG_STATE}, 32'h0);

        // BOOT edge: still a bubble, chip select now active
        tick();
        check_eq("boot_bubble", {31'h0, bus.VALID_IFID}, 32'h0);
        check_eq("run_csn", {31'h0, bus.I_MEM_CSN}, 32'h0);

        // First valid fetch two edges after reset release
        tick();
        check_eq("f0_valid", {31'h0, bus.VALID_IFID}, 32'h1);
        check_eq("f0_pc", bus.PC_IFID, 32'h0);
        check_eq("f0_instr", bus.INSTR_IFID, 32'h0010_0093);
        tick();
        check_eq("f1_pc", bus.PC_IFID, 32'h4);
        check_eq("f1_instr", bus.INSTR_IFID, 32'h0010_0094);
        check_eq("f1_addr", {20'h0, bus.I_MEM_ADDR}, 32'h8);

        // Stall three edges at PC=8
        bus.STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("stall_pc_ifid", bus.PC_IFID, 32'h4);
            check_eq("stall_instr", bus.INSTR_IFID, 32'h0010_0094);
            check_eq("stall_valid", {31'h0, bus.VALID_IFID}, 32'h1);
            check_eq("stall_addr", {20'h0, bus.I_MEM_ADDR}, 32'h8);
        end
        bus.STALL = 1'b0;
        tick();
        check_eq("resume_pc", bus.PC_IFID, 32'h8);
        check_eq("resume_instr", bus.INSTR_IFID, 32'h0010_0095);

        // Redirect wins over simultaneous stall; target bits[1:0] dropped
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h0000_0043;
        bus.STALL       = 1'b1;
        tick();
        check_eq("redir_valid", {31'h0, bus.VALID_IFID}, 32'h0);
        check_eq("redir_instr", bus.INSTR_IFID, 32'h0000_0013);
        check_eq("redir_addr", {20'h0, bus.I_MEM_ADDR}, 32'h40);
        bus.REDIRECT = 1'b0;
        bus.STALL    = 1'b0;
        tick();
        check_eq("redir_pc_ifid", bus.PC_IFID, 32'h40);
        check_eq("redir_fetch", bus.INSTR_IFID, 32'h0010_00a3);

        // Halt sequence at 0x10/0x14
        mem[4] = 32'h00c0_0093;
        mem[5] = 32'h0000_8067;
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h0000_0010;
        tick();
        bus.REDIRECT = 1'b0;
        tick();
        check_eq("h0_instr", bus.INSTR_IFID, 32'h00c0_0093);
        check_eq("h0_halted", {31'h0, bus.HALTED}, 32'h0);
        tick();
        check_eq("h1_instr", bus.INSTR_IFID, 32'h0000_8067);
        check_eq("h1_pc", bus.PC_IFID, 32'h14);
        check_eq("h1_halted", {31'h0, bus.HALTED}, 32'h1);
        tick();
        check_eq("halt_valid", {31'h0, bus.VALID_IFID}, 32'h0);
        check_eq("halt_csn", {31'h0, bus.I_MEM_CSN}, 32'h1);
        check_eq("halt_addr", {20'h0, bus.I_MEM_ADDR}, 32'h14);
        check_eq("halt_state", {30'h0, bus.DBG_STATE}, 32'h2);
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h0;
        bus.STALL       = 1'b1;
        tick();
        tick();
        check_eq("halt_ign_addr", {20'h0, bus.I_MEM_ADDR}, 32'h14);
        check_eq("halt_ign_halted", {31'h0, bus.HALTED}, 32'h1);
        check_eq("halt_ign_valid", {31'h0, bus.VALID_IFID}, 32'h0);
        bus.REDIRECT = 1'b0;
        bus.STALL    = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("halt_rst_halted", {31'h0, bus.HALTED}, 32'h0);
        check_eq("halt_rst_state", {30'h0, bus.DBG_STATE}, 32'h0);
        check_eq("halt_rst_csn", {31'h0, bus.I_MEM_CSN}, 32'h1);
        load_default_mem();

        // PC wrap from FFFF_FFFC to 0
        tick();
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'hFFFF_FFFF;
        tick();
        check_eq("wrap_addr0", {20'h0, bus.I_MEM_ADDR}, 32'hFFC);
        bus.REDIRECT = 1'b0;
        tick();
        check_eq("wrap_pc_a", bus.PC_IFID, 32'hFFFF_FFFC);
        check_eq("wrap_instr_a", bus.INSTR_IFID, 32'h0010_0492);
        check_eq("wrap_addr1", {20'h0, bus.I_MEM_ADDR}, 32'h0);
        tick();
        check_eq("wrap_pc_b", bus.PC_IFID, 32'h0);
        check_eq("wrap_instr_b", bus.INSTR_IFID, 32'h0010_0093);

`ifdef PIPE_FETCH_STATS_EN
        // Counters: 5 fetches, 2 stalls, 1 redirect
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) tick();
        bus.STALL = 1'b1;
        tick();
        tick();
        bus.STALL       = 1'b0;
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h0000_0100;
        tick();
        bus.REDIRECT = 1'b0;
        check_eq("cnt_fetch", bus.FETCH_CNT, 32'd5);
        check_eq("cnt_stall", bus.STALL_CNT, 32'd2);
        check_eq("cnt_squash", bus.SQUASH_CNT, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("cnt_rst_fetch", bus.FETCH_CNT, 32'd0);
        check_eq("cnt_rst_stall", bus.STALL_CNT, 32'd0);
        check_eq("cnt_rst_squash", bus.SQUASH_CNT, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
